// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store, 0 = load
//   req_funct3          : RV32I width code (B/H/W/BU/HU)
//   req_addr/req_wdata  : byte address and store data
//   resp_valid          : one-cycle response strobe
//   resp_rdata/resp_err : formatted load data / access error, qualified by resp_valid
//   busy                : request outstanding, pipeline stall source
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store at a time,
// answers after a fixed LATENCY, formats RV32I load data and byte-merges stores.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : data_mem_responder_if slave port (request, response, busy)
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            write_q;
    logic [2:0]      funct3_q;
    logic [31:0]     addr_q, wdata_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Operation being resolved on the edge entering RESP. With LATENCY == 1 that
    // edge is the accept edge itself, so the live request is used in IDLE.
    logic            op_live;
    logic            op_write;
    logic [2:0]      op_funct3;
    logic [31:0]     op_addr, op_wdata;
    logic [IdxW-1:0] op_idx;
    logic [1:0]      op_lane;
    logic            op_err;
    logic [3:0]      op_be;
    logic [31:0]     op_wbytes;
    logic [31:0]     op_word, load_data;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic            enter_resp;
    logic            unused_addr_bits;

    assign op_live   = (state_q == StIdle);
    assign op_write  = op_live ? bus.req_write  : write_q;
    assign op_funct3 = op_live ? bus.req_funct3 : funct3_q;
    assign op_addr   = op_live ? bus.req_addr   : addr_q;
    assign op_wdata  = op_live ? bus.req_wdata  : wdata_q;
    assign op_idx    = op_addr[IdxW+1:2];
    assign op_lane   = op_addr[1:0];
    assign unused_addr_bits = ^op_addr[31:IdxW+2];

    // Next state and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    cnt_d   = CntInit;
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Reset wins over the RESP transition, so a reset store never commits.
    assign enter_resp = (state_d == StResp) && (state_q != StResp) && !reset;

    // Error check, byte enables and store lane replication
    always_comb begin
        op_err    = 1'b0;
        op_be     = 4'hF;
        op_wbytes = op_wdata;
        case (op_funct3)
            3'd0:    op_err = 1'b0;
            3'd1:    op_err = op_addr[0];
            3'd2:    op_err = |op_addr[1:0];
            3'd4:    op_err = op_write;
            3'd5:    op_err = op_write | op_addr[0];
            default: op_err = 1'b1;
        endcase
        case (op_funct3[1:0])
            2'd0: begin
                op_be     = 4'b0001 << op_lane;
                op_wbytes = {4{op_wdata[7:0]}};
            end
            2'd1: begin
                op_be     = op_lane[1] ? 4'b1100 : 4'b0011;
                op_wbytes = {2{op_wdata[15:0]}};
            end
            default: begin
                op_be     = 4'hF;
                op_wbytes = op_wdata;
            end
        endcase
    end

    // Load formatting
    always_comb begin
        op_word  = mem[op_idx];
        sel_byte = op_word[8*op_lane +: 8];
        sel_half = op_lane[1] ? op_word[31:16] : op_word[15:0];
        case (op_funct3)
            3'd0:    load_data = {{24{sel_byte[7]}}, sel_byte};
            3'd1:    load_data = {{16{sel_half[15]}}, sel_half};
            3'd2:    load_data = op_word;
            3'd4:    load_data = {24'd0, sel_byte};
            3'd5:    load_data = {16'd0, sel_half};
            default: load_data = 32'd0;
        endcase
    end

    // Response registers hold outside RESP
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = op_err;
            rdata_d = (op_err || op_write) ? 32'd0 : load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (op_live && bus.req_valid) begin
                write_q  <= bus.req_write;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
        end
    end

    // Storage is not cleared by reset
    always_ff @(posedge clk) begin
        if (enter_resp && op_write && !op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be[i]) begin
                    mem[op_idx][8*i +: 8] <= op_wbytes[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2/1024-word instance and a
// LATENCY=1/16-word instance, checked against a byte-array memory model.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic reset2 = 1'b1;
    logic reset1 = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [7:0] ref2 [4096];
    logic [7:0] ref1 [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array; accesses described by size in bytes.
    function automatic void model(input bit sel1, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rd, output bit err);
        int unsigned size, base;
        logic [31:0] val;
        bit legal;
        base = sel1 ? (a & 32'h3F) : (a & 32'hFFF);
        if (wr) legal = (f3 <= 3'd2);
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = 1 << f3[1:0];
        err  = !legal || ((a % size) != 0);
        rd   = 32'd0;
        if (err) return;
        if (wr) begin
            for (int i = 0; i < int'(size); i++) begin
                if (sel1) ref1[base + i] = d[8*i +: 8];
                else      ref2[base + i] = d[8*i +: 8];
            end
        end else begin
            val = 32'd0;
            for (int i = 0; i < int'(size); i++) begin
                val[8*i +: 8] = sel1 ? ref1[base + i] : ref2[base + i];
            end
            if (!f3[2] && size < 4) begin
                for (int j = 8 * int'(size); j < 32; j++) val[j] = val[8*size-1];
            end
            rd = val;
        end
    endfunction

    task automatic drive(input bit sel1, input logic v, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel1) begin
            bus1.req_valid = v; bus1.req_write = wr; bus1.req_funct3 = f3;
            bus1.req_addr = a;  bus1.req_wdata = d;
        end else begin
            bus2.req_valid = v; bus2.req_write = wr; bus2.req_funct3 = f3;
            bus2.req_addr = a;  bus2.req_wdata = d;
        end
    endtask

    function automatic logic rdy(input bit sel1);
        return sel1 ? bus1.req_ready : bus2.req_ready;
    endfunction
    function automatic logic rv(input bit sel1);
        return sel1 ? bus1.resp_valid : bus2.resp_valid;
    endfunction
    function automatic logic [31:0] rdat(input bit sel1);
        return sel1 ? bus1.resp_rdata : bus2.resp_rdata;
    endfunction
    function automatic logic rerr(input bit sel1);
        return sel1 ? bus1.resp_err : bus2.resp_err;
    endfunction
    function automatic logic bsy(input bit sel1);
        return sel1 ? bus1.busy : bus2.busy;
    endfunction

    task automatic check_reset_outputs(input bit sel1, input string tag);
        check({tag, "/ready"}, 32'(rdy(sel1)), 32'd1);
        check({tag, "/valid"}, 32'(rv(sel1)), 32'd0);
        check({tag, "/rdata"}, rdat(sel1), 32'd0);
        check({tag, "/err"}, 32'(rerr(sel1)), 32'd0);
        check({tag, "/busy"}, 32'(bsy(sel1)), 32'd0);
    endtask

    // One full transaction. Garbage requests are driven while busy; they must be ignored.
    task automatic xact(input bit sel1, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
        logic [31:0] exp_rd;
        bit exp_err;
        int lat, n, low, bad;
        lat = sel1 ? 1 : 2;
        model(sel1, wr, f3, a, d, exp_rd, exp_err);
        @(negedge clk);
        check({tag, "/ready_in"}, 32'(rdy(sel1)), 32'd1);
        drive(sel1, 1'b1, wr, f3, a, d);
        @(posedge clk);
        n = 0; low = 0; bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (!rdy(sel1)) low++;
            if (bsy(sel1) !== !rdy(sel1)) bad++;
            drive(sel1, 1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom);
        end while (!rv(sel1) && n < 20);
        check({tag, "/latency"}, 32'(n), 32'(lat));
        check({tag, "/rdata"}, rdat(sel1), exp_rd);
        check({tag, "/err"}, 32'(rerr(sel1)), 32'(exp_err));
        @(negedge clk);
        check({tag, "/ready_out"}, 32'(rdy(sel1)), 32'd1);
        check({tag, "/strobe"}, 32'(rv(sel1)), 32'd0);
        check({tag, "/low_cycles"}, 32'(low), 32'(lat));
        check({tag, "/busy_track"}, 32'(bad), 32'd0);
        drive(sel1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rd_exp;
        logic [2:0]  rf;
        bit          re;
        int          acc, resps, bad;

        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset2 = 1'b0;
        reset1 = 1'b0;
        check_reset_outputs(0, "rst2");
        check_reset_outputs(1, "rst1");

        // Word round trip and formatting
        xact(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10");
        xact(0, 0, 3'd2, 32'h10, 32'h0, "lw10");
        xact(0, 0, 3'd0, 32'h13, 32'h0, "lb13");
        xact(0, 0, 3'd4, 32'h13, 32'h0, "lbu13");
        xact(0, 0, 3'd1, 32'h10, 32'h0, "lh10");
        xact(0, 0, 3'd5, 32'h12, 32'h0, "lhu12");

        // Partial store merge
        xact(0, 1, 3'd0, 32'h11, 32'h12345677, "sb11");
        xact(0, 0, 3'd2, 32'h10, 32'h0, "lw10_sb");
        check("merge_sb_const", dut2.bus.resp_rdata, 32'hDEAD77EF);
        xact(0, 1, 3'd1, 32'h12, 32'hAAAA1234, "sh12");
        xact(0, 0, 3'd2, 32'h10, 32'h0, "lw10_sh");
        check("merge_sh_const", bus2.resp_rdata, 32'h123477EF);

        // Errors
        xact(0, 0, 3'd2, 32'h02, 32'h0, "lw02_err");
        xact(0, 1, 3'd2, 32'h04, 32'h0BADC0DE, "sw04");
        xact(0, 1, 3'd1, 32'h05, 32'hFFFFFFFF, "sh05_err");
        xact(0, 0, 3'd2, 32'h04, 32'h0, "lw04_keep");
        xact(0, 0, 3'd3, 32'h10, 32'h0, "f3_3_err");
        xact(0, 1, 3'd4, 32'h10, 32'h0, "st_f3_4_err");

        // Wrap
        xact(0, 1, 3'd2, 32'h1000, 32'h5A5A5A5A, "sw1000");
        xact(0, 0, 3'd2, 32'h0, 32'h0, "lw0_wrap");

        // Continuous req_valid: one accept per LATENCY+1 cycles
        model(0, 0, 3'd2, 32'h10, 32'h0, rd_exp, re);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        acc = 0; resps = 0; bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus2.req_ready) acc++;
            if (bus2.resp_valid) resps++;
            if (bus2.busy !== !bus2.req_ready) bad++;
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check("stream/accepts", 32'(acc), 32'd4);
        check("stream/resps", 32'(resps), 32'd4);
        check("stream/busy", 32'(bad), 32'd0);
        check("stream/rdata", bus2.resp_rdata, rd_exp);
        repeat (3) @(negedge clk);

        // Reset during WAIT drops the store
        xact(0, 1, 3'd2, 32'h20, 32'hCAFEF00D, "sw20");
        xact(0, 0, 3'd2, 32'h20, 32'h0, "lw20_pre");
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 3'd2, 32'h20, 32'h11111111);
        @(posedge clk);
        @(negedge clk);
        check("midrst2/in_wait", 32'(bus2.busy), 32'd1);
        reset2 = 1'b1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs(0, "midrst2");
        reset2 = 1'b0;
        xact(0, 0, 3'd2, 32'h20, 32'h0, "lw20_post");
        check("midrst2/prior", bus2.resp_rdata, 32'hCAFEF00D);

        // LATENCY=1 instance: direct IDLE->RESP, reset in RESP keeps the store
        for (int w = 0; w < 16; w++) xact(1, 1, 3'd2, 32'(4 * w), $urandom, "l1_init");
        xact(1, 1, 3'd2, 32'h20, 32'hCAFEF00D, "l1_sw20");
        xact(1, 0, 3'd2, 32'h20, 32'h0, "l1_lw20");
        xact(1, 0, 3'd0, 32'h23, 32'h0, "l1_lb23");
        xact(1, 0, 3'd5, 32'h21, 32'h0, "l1_lhu21_err");
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 3'd2, 32'h20, 32'h11111111);
        @(posedge clk);
        @(negedge clk);
        check("midrst1/in_resp", 32'(bus1.resp_valid), 32'd1);
        model(1, 1, 3'd2, 32'h20, 32'h11111111, rd_exp, re);
        reset1 = 1'b1;
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs(1, "midrst1");
        reset1 = 1'b0;
        xact(1, 0, 3'd2, 32'h20, 32'h0, "l1_lw20_post");
        check("midrst1/committed", bus1.resp_rdata, 32'h11111111);

        // Randomized traffic against the model
        for (int w = 0; w < 16; w++) xact(0, 1, 3'd2, 32'h100 + 32'(4 * w), $urandom, "r_init");
        for (int t = 0; t < 60; t++) begin
            ra = $urandom;
            ra[11:0] = 12'h100 + 12'($urandom_range(0, 63));
            rf = 3'($urandom_range(0, 7));
            xact(0, 1'($urandom), rf, ra, $urandom, "rand2");
        end
        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            rf = 3'($urandom_range(0, 7));
            xact(1, 1'($urandom), rf, ra, $urandom, "rand1");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
